pio_ctrl_io_lvds_pulse: RTL
===========================

// Module: pio_ctrl_io_lvds_pulse
// PURPOSE
//  Avalon-MM slave PIO driving the LVDS transceiver control lines (enable/power-down/pre-emphasis).
//  Successor to the fixed 4-bit output PIO: parametrised width and reset pattern.
//  Adds atomic set/clear registers and a hardware-timed pulse engine.
//  The pulse engine inverts selected bits for an exact cycle count, then restores them.
//  Sits in MebX Qsys on the control clock domain, readLatency 0, no waitrequest.
// PARAMETERS
//  DATA_W        4       number of control outputs (1..32)
//  RESET_VALUE   4'h4    out_port / DATA value after reset
//  CNT_W         16      pulse length counter width (1..32)
//  PULSE_LEN_RST 100     PULSE_LEN register reset value (cycles)
// PORTS
//  clk         in   1       system clock; single clock domain
//  reset       in   1       synchronous, active-high reset
//  address     in   3       word address
//  chipselect  in   1       slave select
//  write_n     in   1       active-low write strobe
//  writedata   in   32      write data; bits above DATA_W/CNT_W ignored
//  readdata    out  32      combinational read mux; unused bits 0
//  out_port    out  DATA_W  registered control outputs
// BEHAVIOUR
//  Write = chipselect & ~write_n, sampled on rising clk.
//  Register map:
//   0 DATA   RW  data_out
//   1 SET    WO  data_out |= wd; reads 0
//   2 CLR    WO  data_out &= ~wd; reads 0
//   3 PULSE  W: start pulse with mask wd[DATA_W-1:0]; R: latched mask while busy, else 0
//   4 PLEN   RW  pulse length, CNT_W bits
//   5 STATUS R: bit0 busy, bit1 overrun (sticky); W: 1 to bit1 clears overrun
//   6,7      reads 0; writes ignored
//  Reset (reset=1 at an edge):
//   data_out = out_port = RESET_VALUE; PLEN = PULSE_LEN_RST
//   cnt = 0; mask = 0; busy = 0; overrun = 0
//   Reset mid-pulse aborts the pulse immediately.
//  Output register: out_port <= data_next ^ (cnt_next != 0 ? mask_next : 0).
//   Any write takes effect on out_port at the same edge that samples it.
//  Pulse engine: one shared down-counter, busy = (cnt != 0).
//   PULSE write, not busy, PLEN != 0, at edge N:
//    cnt <= PLEN; mask <= wd
//    masked bits invert at edge N and restore at edge N+PLEN; width exactly PLEN cycles.
//   PULSE write while busy: ignored, overrun <= 1; pulse in flight unaffected.
//   PULSE write with PLEN = 0, or mask = 0: no-op; busy stays 0; no overrun.
//   cnt decrements by 1 each edge while nonzero; no wrap below 0.
//  Interactions:
//   DATA/SET/CLR during a pulse update data_out; out_port = new data ^ mask until the pulse ends.
//   Writing PLEN during a pulse affects only the next pulse.
//   Overrun set and clear in the same cycle cannot occur (distinct addresses).
//  Read mux is purely combinational on address and current register state.
// STRUCTURE
//  Package pio_lvds_pkg: address localparams (ADDR_DATA..ADDR_STATUS), STATUS bit indices.
//  Sub-module pio_pulse_timer (CNT_W): inputs start/len; outputs busy, one-cycle done.
//   Holds cnt; mask register and overrun flag stay in the top level.
//  Top level: Avalon decode, data/PLEN/mask/status registers, output register, read mux.
// TESTING
//  1 Reset -> out_port=4'h4, PLEN reads 100, STATUS=0, all other reads 0.
//  2 Write DATA=0x3, SET=0x8, CLR=0x1 -> out_port 0x3, 0xB, 0xA on each write edge.
//    DATA reads 0xA; SET and CLR read 0.
//  3 DATA=0x0, PLEN=5, PULSE=0x2 -> out_port=0x2 for exactly 5 cycles, then 0x0.
//    busy high those 5 cycles; PULSE reads 0x2 while busy.
//  4 During a PLEN=10 pulse:
//    write PULSE=0x1 -> ignored, STATUS=0x3.
//    SET=0x4 mid-pulse -> out_port=0x6 then 0x4.
//    STATUS write 0x2 -> overrun clears.
//  5 PLEN=0 then PULSE=0xF -> out_port unchanged, busy never asserts, no overrun.
//  6 Assert reset 3 cycles into a PLEN=8 pulse -> next edge out_port=0x4, busy=0, PLEN=100.
//    DATA_W=8, CNT_W=4 variant: PLEN write 0x1F reads 0xF.

Source files
------------

// File: rtl/pio_ctrl_io_lvds_pulse_pkg.sv
// Shared register map and STATUS bit positions for the LVDS control PIO.
package pio_lvds_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_PLEN   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;

endpackage

// File: rtl/pio_ctrl_io_lvds_pulse_if.sv
// Avalon-MM slave bus (readLatency 0, no waitrequest): a write is accepted
// on any rising clk where chipselect=1 and write_n=0; readdata is valid combinationally.
interface pio_ctrl_io_lvds_pulse_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_ctrl_io_lvds_pulse_timer.sv
// Pulse length down-counter: loads on start, counts to zero, busy while nonzero.
module pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_busy_next,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_start)
      w_cnt_next = i_len;
    else if (r_cnt != '0)
      w_cnt_next = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_next;
  end

  // o_busy_next lets the owner register its output with the post-edge pulse state.
  assign o_busy      = (r_cnt != '0);
  assign o_busy_next = (w_cnt_next != '0);
  assign o_done      = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pio_ctrl_io_lvds_pulse.sv
// LVDS control PIO: DATA/SET/CLR registers plus a timed invert-and-restore pulse engine.
module pio_ctrl_io_lvds_pulse
  import pio_lvds_pkg::*;
#(
  parameter int                DATA_W        = 4,
  parameter logic [DATA_W-1:0] RESET_VALUE   = DATA_W'(4'h4),
  parameter int                CNT_W         = 16,
  parameter logic [CNT_W-1:0]  PULSE_LEN_RST = CNT_W'(100)
) (
  input  logic                     clk,
  input  logic                     reset,
  pio_ctrl_io_lvds_pulse_if.slave  bus,
  output logic [DATA_W-1:0]        out_port
);

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_plen;
  logic [DATA_W-1:0] r_mask;
  logic              r_overrun;

  logic              w_wr;
  logic [DATA_W-1:0] w_wd_data;
  logic [CNT_W-1:0]  w_wd_cnt;
  logic              w_pulse_wr;
  logic              w_start;
  logic              w_busy;
  logic              w_busy_next;
  logic              w_done;
  logic [DATA_W-1:0] w_data_next;
  logic [DATA_W-1:0] w_mask_next;
  logic              w_unused_wd;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wd_data   = bus.writedata[DATA_W-1:0];
  assign w_wd_cnt    = bus.writedata[CNT_W-1:0];
  assign w_unused_wd = ^bus.writedata;

  // A zero mask or zero length would never change out_port, so it is not a pulse.
  assign w_pulse_wr = w_wr && (bus.address == ADDR_PULSE);
  assign w_start    = w_pulse_wr && !w_busy && (r_plen != '0) && (w_wd_data != '0);

  pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_start     (w_start),
    .i_len       (r_plen),
    .o_busy      (w_busy),
    .o_busy_next (w_busy_next),
    .o_done      (w_done)
  );

  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (bus.address)
        ADDR_DATA: w_data_next = w_wd_data;
        ADDR_SET:  w_data_next = r_data | w_wd_data;
        ADDR_CLR:  w_data_next = r_data & ~w_wd_data;
        default:   w_data_next = r_data;
      endcase
    end
  end

  assign w_mask_next = w_start ? w_wd_data : (w_done ? '0 : r_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= RESET_VALUE;
      r_plen    <= PULSE_LEN_RST;
      r_mask    <= '0;
      r_overrun <= 1'b0;
      out_port  <= RESET_VALUE;
    end else begin
      r_data <= w_data_next;
      r_mask <= w_mask_next;
      if (w_wr && (bus.address == ADDR_PLEN))
        r_plen <= w_wd_cnt;
      if (w_pulse_wr && w_busy)
        r_overrun <= 1'b1;
      else if (w_wr && (bus.address == ADDR_STATUS) && bus.writedata[STAT_OVERRUN])
        r_overrun <= 1'b0;
      out_port <= w_data_next ^ (w_busy_next ? w_mask_next : '0);
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:   bus.readdata[DATA_W-1:0] = r_data;
      ADDR_PULSE:  bus.readdata[DATA_W-1:0] = w_busy ? r_mask : '0;
      ADDR_PLEN:   bus.readdata[CNT_W-1:0]  = r_plen;
      ADDR_STATUS: begin
        bus.readdata[STAT_BUSY]    = w_busy;
        bus.readdata[STAT_OVERRUN] = r_overrun;
      end
      default:     bus.readdata = '0;
    endcase
  end

endmodule
